// File: rtl/bram_multi_if.sv
// Bus bundle for bram_multi: write/read request strobes, clear request,
// and the read-data return path.
//
// Request semantics: wen[i]/ren[i] are single-cycle strobes sampled on every
// rising edge. They are accepted whenever busy is low. There is no per-request
// ready signal; busy acts as a global "not ready" that drops requests while the
// clear sweep runs. dvalid[i] is a one-cycle completion strobe with dout
// holding its value between completions.
interface bram_multi_if #(
    parameter int DLEN = 32,
    parameter int HLEN = 9,
    parameter int CH   = 2
);
    logic                 clr;
    logic                 busy;
    logic [CH-1:0]        wen;
    logic [CH*HLEN-1:0]   waddr;
    logic [CH*DLEN-1:0]   din;
    logic [CH-1:0]        ren;
    logic [CH*HLEN-1:0]   raddr;
    logic [CH*DLEN-1:0]   dout;
    logic [CH-1:0]        dvalid;
    logic                 dbg_state;

    modport master (
        output clr, wen, waddr, din, ren, raddr,
        input  busy, dout, dvalid, dbg_state
    );

    modport slave (
        input  clr, wen, waddr, din, ren, raddr,
        output busy, dout, dvalid, dbg_state
    );
endinterface

// File: rtl/bram_multi.sv
// Multi-channel block-RAM bank: CH independent DLEN x 2^HLEN memories, each
// with one write and one read port, a RD_LAT-deep read pipeline with valid
// strobe, selectable read/write collision behaviour, and a clear sequencer
// that zeroes every channel in a single 2^HLEN-cycle sweep.
module bram_multi #(
    parameter int DLEN    = 32,
    parameter int HLEN    = 9,
    parameter int CH      = 2,
    parameter int RD_LAT  = 1,
    parameter int RW_MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    bram_multi_if.slave  bus
);
    localparam int DEPTH = 2 ** HLEN;
    localparam logic [HLEN-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [HLEN-1:0] cnt, cnt_nxt;
    logic            busy;

    // Clear sequencer state and sweep address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: clr starts a sweep from IDLE only; the sweep ends
    // after the cycle that writes the last address.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + HLEN'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy          = (state == CLEAR);
    assign bus.busy      = busy;
    assign bus.dbg_state = logic'(state);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [HLEN-1:0] wa, ra;
        logic [DLEN-1:0] wd;
        logic            we, re;
        logic [DLEN-1:0] mem [DEPTH];
        logic [DLEN-1:0] pd  [RD_LAT];
        logic [RD_LAT-1:0] pv;

        // User requests are dropped while the sweep owns the memory.
        assign wa = bus.waddr[g*HLEN +: HLEN];
        assign ra = bus.raddr[g*HLEN +: HLEN];
        assign wd = bus.din[g*DLEN +: DLEN];
        assign we = bus.wen[g] & ~busy;
        assign re = bus.ren[g] & ~busy;

        // Storage write port; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (busy) begin
                mem[cnt] <= '0;
            end else if (we) begin
                mem[wa] <= wd;
            end
        end

        // Read pipeline: stage 0 is the BRAM output register, later stages
        // only advance on valid data so the last stage holds the last result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < RD_LAT; k++) begin
                    pd[k] <= '0;
                end
                pv <= '0;
            end else begin
                pv[0] <= re;
                if (re) begin
                    if (RW_MODE == 1 && we && (wa == ra)) begin
                        pd[0] <= wd;
                    end else begin
                        pd[0] <= mem[ra];
                    end
                end
                for (int k = 1; k < RD_LAT; k++) begin
                    pv[k] <= pv[k-1];
                    if (pv[k-1]) begin
                        pd[k] <= pd[k-1];
                    end
                end
            end
        end

        assign bus.dout[g*DLEN +: DLEN] = pd[RD_LAT-1];
        assign bus.dvalid[g]            = pv[RD_LAT-1];
    end
endmodule

// File: tb/tb_bram_multi.sv
// Directed bench for bram_multi. Three instances share one stimulus stream
// and differ in read latency and collision mode, so every scenario is checked
// against each configuration's own expected timing.
module tb_bram_multi;
    localparam int DLEN = 32;
    localparam int HLEN = 4;
    localparam int CH   = 2;
    localparam int ND   = 3;
    localparam int LAT  [ND] = '{1, 3, 2};
    localparam int MODE [ND] = '{0, 1, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                 clr;
    logic [CH-1:0]        wen, ren;
    logic [CH*HLEN-1:0]   waddr, raddr;
    logic [CH*DLEN-1:0]   din;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock generation.
    always #5 clk = ~clk;

    bram_multi_if #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH)) if_a ();
    bram_multi_if #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH)) if_b ();
    bram_multi_if #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH)) if_c ();

    bram_multi #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH), .RD_LAT(1), .RW_MODE(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    bram_multi #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH), .RD_LAT(3), .RW_MODE(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    bram_multi #(.DLEN(DLEN), .HLEN(HLEN), .CH(CH), .RD_LAT(2), .RW_MODE(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.clr = clr; assign if_a.wen = wen; assign if_a.waddr = waddr;
    assign if_a.din = din; assign if_a.ren = ren; assign if_a.raddr = raddr;
    assign if_b.clr = clr; assign if_b.wen = wen; assign if_b.waddr = waddr;
    assign if_b.din = din; assign if_b.ren = ren; assign if_b.raddr = raddr;
    assign if_c.clr = clr; assign if_c.wen = wen; assign if_c.waddr = waddr;
    assign if_c.din = din; assign if_c.ren = ren; assign if_c.raddr = raddr;

    logic [CH*DLEN-1:0] dout_o [ND];
    logic [CH-1:0]      dv_o   [ND];
    logic               busy_o [ND];

    assign dout_o[0] = if_a.dout; assign dv_o[0] = if_a.dvalid; assign busy_o[0] = if_a.busy;
    assign dout_o[1] = if_b.dout; assign dv_o[1] = if_b.dvalid; assign busy_o[1] = if_b.busy;
    assign dout_o[2] = if_c.dout; assign dv_o[2] = if_c.dvalid; assign busy_o[2] = if_c.busy;

    // Driver tasks: all stimulus changes happen on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clr = 1'b0; wen = '0; ren = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill(input logic [31:0] v0, input logic [31:0] v1, input bit add);
        for (int a = 0; a < 16; a++) begin
            logic [3:0] av;
            av    = a[3:0];
            wen   = 2'b11;
            waddr = {av, av};
            din   = {v1 + (add ? 32'(a) : 32'd0), v0 + (add ? 32'(a) : 32'd0)};
            tick();
        end
        wen = '0;
    endtask

    // Reads addresses 0..15 back-to-back and checks each completion in order.
    // Addresses below zero_below are expected to read zero.
    task automatic read_sweep(input string name, input logic [31:0] v0, input logic [31:0] v1,
                              input bit add, input int zero_below);
        idle(5);
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) begin
                for (int d = 0; d < ND; d++) begin
                    int s;
                    logic [1:0]  ev;
                    logic [63:0] ed;
                    s  = t - LAT[d];
                    ev = (s >= 0 && s < 16) ? 2'b11 : 2'b00;
                    n_checks++;
                    if (dv_o[d] !== ev) begin
                        n_fail++;
                        $display("FAIL %s_valid dut%0d t=%0d: got %b expected %b", name, d, t, dv_o[d], ev);
                    end
                    if (ev == 2'b11) begin
                        if (s < zero_below) ed = '0;
                        else ed = {v1 + (add ? 32'(s) : 32'd0), v0 + (add ? 32'(s) : 32'd0)};
                        n_checks++;
                        if (dout_o[d] !== ed) begin
                            n_fail++;
                            $display("FAIL %s_data dut%0d addr=%0d: got %h expected %h", name, d, s, dout_o[d], ed);
                        end
                    end
                end
            end
            if (t < 16) begin
                logic [3:0] av;
                av    = t[3:0];
                ren   = 2'b11;
                raddr = {av, av};
            end else begin
                ren = '0;
            end
            tick();
        end
        ren = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0; wen = '0; ren = '0; waddr = '0; raddr = '0; din = '0;
        tick(); tick();
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (busy_o[d] !== 1'b0 || dv_o[d] !== 2'b00 || dout_o[d] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got busy=%b dvalid=%b dout=%h expected 0/00/0", d, busy_o[d], dv_o[d], dout_o[d]);
            end
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        wen = 2'b11; waddr = {4'd5, 4'd5}; din = {32'h12345678, 32'hDEADBEEF};
        tick();
        wen = '0;
        idle(1);
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) begin
                for (int d = 0; d < ND; d++) begin
                    logic [1:0] ev;
                    ev = (j == LAT[d]) ? 2'b11 : 2'b00;
                    n_checks++;
                    if (dv_o[d] !== ev) begin
                        n_fail++;
                        $display("FAIL basic_valid dut%0d j=%0d: got %b expected %b", d, j, dv_o[d], ev);
                    end
                    if (j >= LAT[d]) begin
                        n_checks++;
                        if (dout_o[d] !== {32'h12345678, 32'hDEADBEEF}) begin
                            n_fail++;
                            $display("FAIL basic_data dut%0d j=%0d: got %h expected %h", d, j, dout_o[d], {32'h12345678, 32'hDEADBEEF});
                        end
                    end
                end
            end
            ren   = (j == 0) ? 2'b11 : 2'b00;
            raddr = {4'd5, 4'd5};
            tick();
        end
        ren = '0;
    endtask

    task automatic test_back_to_back();
        fill(32'd0, 32'd100, 1'b1);
        read_sweep("b2b", 32'd0, 32'd100, 1'b1, 0);
    endtask

    task automatic test_collision();
        wen = 2'b11; waddr = {4'd7, 4'd7}; din = {32'h0000AAAA, 32'h0000AAAA};
        tick();
        wen = '0;
        idle(1);
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j <= 4; j++) begin
                if (j > 0) begin
                    for (int d = 0; d < ND; d++) begin
                        if (j == LAT[d]) begin
                            logic [63:0] ed;
                            ed = (pass == 1 || MODE[d] == 1) ? {32'h5555, 32'h5555} : {32'hAAAA, 32'hAAAA};
                            n_checks++;
                            if (dv_o[d] !== 2'b11 || dout_o[d] !== ed) begin
                                n_fail++;
                                $display("FAIL collision%0d dut%0d: got dvalid=%b dout=%h expected 11/%h", pass, d, dv_o[d], dout_o[d], ed);
                            end
                        end
                    end
                end
                wen   = (j == 0 && pass == 0) ? 2'b11 : 2'b00;
                din   = {32'h5555, 32'h5555};
                ren   = (j == 0) ? 2'b11 : 2'b00;
                raddr = {4'd7, 4'd7};
                tick();
            end
        end
        idle(1);
    endtask

    task automatic test_clear();
        fill(32'hFF, 32'hFF, 1'b0);
        idle(4);
        clr = 1'b1;
        tick();
        for (int t = 1; t <= 18; t++) begin
            for (int d = 0; d < ND; d++) begin
                logic eb;
                eb = (t <= 16);
                n_checks++;
                if (busy_o[d] !== eb) begin
                    n_fail++;
                    $display("FAIL clear_busy dut%0d t=%0d: got %b expected %b", d, t, busy_o[d], eb);
                end
                n_checks++;
                if (dv_o[d] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL clear_dvalid dut%0d t=%0d: got %b expected 00", d, t, dv_o[d]);
                end
            end
            clr   = (t == 8);
            wen   = (t <= 15) ? 2'b11 : 2'b00;
            ren   = (t <= 15) ? 2'b11 : 2'b00;
            waddr = {4'd3, 4'd3};
            raddr = {4'd3, 4'd3};
            din   = {32'h77, 32'h77};
            tick();
        end
        idle(1);
        read_sweep("clear", 32'hFF, 32'hFF, 1'b0, 16);
    endtask

    task automatic test_reset_mid_clear();
        fill(32'hC3, 32'h3C, 1'b0);
        ren = 2'b11; raddr = '0;
        tick();
        idle(4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int t = 1; t <= 8; t++) tick();
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (busy_o[d] !== 1'b1 || dout_o[d] !== {32'h3C, 32'hC3}) begin
                n_fail++;
                $display("FAIL midclr_pre dut%0d: got busy=%b dout=%h expected 1/%h", d, busy_o[d], dout_o[d], {32'h3C, 32'hC3});
            end
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (busy_o[d] !== 1'b0 || dv_o[d] !== 2'b00 || dout_o[d] !== 64'd0) begin
                n_fail++;
                $display("FAIL midclr_reset dut%0d: got busy=%b dvalid=%b dout=%h expected 0/00/0", d, busy_o[d], dv_o[d], dout_o[d]);
            end
        end
        tick();
        rst_n = 1'b1;
        read_sweep("midclr", 32'hC3, 32'h3C, 1'b0, 8);
    endtask

    task automatic test_reset_inflight();
        idle(5);
        ren = 2'b11; raddr = {4'd9, 4'd9};
        tick();
        ren   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                n_checks++;
                if (dv_o[d] !== 2'b00 || dout_o[d] !== 64'd0) begin
                    n_fail++;
                    $display("FAIL inflight dut%0d j=%0d: got dvalid=%b dout=%h expected 00/0", d, j, dv_o[d], dout_o[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
